// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with programmable modulus,
// load, wrap/saturate mode and status pulses.
module mod_n_counter #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             sat_hit,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] DMOD =
    WIDTH'(DEFAULT_MOD);

  logic [WIDTH-1:0] mod_reg;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] new_top;

  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] mod_n;
  logic             wrap_n;
  logic             sat_n;
  logic             lerr_n;

  logic             step_up;
  logic             step_dn;
  logic             at_top;
  logic             at_zero;

  // Modulus 0 stands for 2^WIDTH, so top wraps to all ones.
  assign top     = mod_reg - ONE;
  assign new_top = mod_val - ONE;

  assign at_top  = (count >= top);
  assign at_zero = (count == ZERO);

  assign step_up = !load && en && up_dn;
  assign step_dn = !load && en && !up_dn;

  assign tc = up_dn ? (count == top) : at_zero;

  always_comb begin
    count_n = count;
    mod_n   = mod_reg;
    wrap_n  = 1'b0;
    sat_n   = 1'b0;
    lerr_n  = 1'b0;
    unique case (1'b1)
      load: begin
        mod_n = mod_val;
        if (load_val <= new_top) begin
          count_n = load_val;
        end else begin
          count_n = new_top;
          lerr_n  = 1'b1;
        end
      end
      step_up: begin
        if (!at_top) begin
          count_n = count + ONE;
        end else if (sat_mode) begin
          sat_n = 1'b1;
        end else begin
          count_n = ZERO;
          mod_n   = mod_val;
          wrap_n  = 1'b1;
        end
      end
      step_dn: begin
        if (!at_zero) begin
          count_n = count - ONE;
        end else if (sat_mode) begin
          sat_n = 1'b1;
        end else begin
          // Down wrap restarts from the newly adopted top.
          count_n = new_top;
          mod_n   = mod_val;
          wrap_n  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= ZERO;
      mod_reg    <= DMOD;
      wrap_pulse <= 1'b0;
      sat_hit    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      count      <= count_n;
      mod_reg    <= mod_n;
      wrap_pulse <= wrap_n;
      sat_hit    <= sat_n;
      load_err   <= lerr_n;
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter.
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] mod_val = 4'd10;

  logic [3:0] count, count2;
  logic       tc, tc2;
  logic       wrap_pulse, wrap2;
  logic       sat_hit, sat2;
  logic       load_err, lerr2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(4), .DEFAULT_MOD(10)) dut (
    .clk(clk), .reset(reset), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .mod_val(mod_val), .count(count), .tc(tc),
    .wrap_pulse(wrap_pulse), .sat_hit(sat_hit),
    .load_err(load_err)
  );

  mod_n_counter #(.WIDTH(4), .DEFAULT_MOD(2)) dut2 (
    .clk(clk), .reset(reset), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .mod_val(mod_val), .count(count2), .tc(tc2),
    .wrap_pulse(wrap2), .sat_hit(sat2),
    .load_err(lerr2)
  );

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    en    = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic flags(input string tag,
                       input int w,
                       input int s,
                       input int l);
    check({tag, ".wrap"}, int'(wrap_pulse), w);
    check({tag, ".sat"},  int'(sat_hit), s);
    check({tag, ".lerr"}, int'(load_err), l);
  endtask

  initial begin
    // Mod-2 toggle equivalence
    mod_val = 4'd2; up_dn = 1'b1; sat_mode = 1'b0;
    do_reset();
    check("t1.cnt0", int'(count2), 0);
    check("t1.wrap0", int'(wrap2), 0);
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t1.cnt%0d", i),
            int'(count2), i % 2);
      check($sformatf("t1.wrap%0d", i),
            int'(wrap2), (i % 2 == 0) ? 1 : 0);
    end

    // Mod-10 up wrap, then hold
    mod_val = 4'd10;
    do_reset();
    check("t2.cnt0", int'(count), 0);
    check("t2.tc0", int'(tc), 0);
    flags("t2.rst", 0, 0, 0);
    en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check($sformatf("t2.cnt%0d", i),
            int'(count), i % 10);
      check($sformatf("t2.tc%0d", i),
            int'(tc), (i % 10 == 9) ? 1 : 0);
      check($sformatf("t2.wrap%0d", i),
            int'(wrap_pulse), (i == 10) ? 1 : 0);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2.hold", int'(count), 1);
      flags("t2.hold", 0, 0, 0);
    end

    // Down wrap then saturate at 0
    up_dn = 1'b0;
    do_reset();
    check("t3.tc0", int'(tc), 1);
    en = 1'b1;
    tick();
    check("t3.cnt9", int'(count), 9);
    check("t3.wrap", int'(wrap_pulse), 1);
    tick();
    check("t3.cnt8", int'(count), 8);
    check("t3.wrapoff", int'(wrap_pulse), 0);
    sat_mode = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick();
      check($sformatf("t3.dn%0d", i),
            int'(count), i);
    end
    check("t3.tcz", int'(tc), 1);
    check("t3.nosat", int'(sat_hit), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3.stick", int'(count), 0);
      flags("t3.sat", 0, 1, 0);
    end

    // Out-of-range load, then full-range load
    sat_mode = 1'b0; up_dn = 1'b1;
    load = 1'b1; mod_val = 4'd5; load_val = 4'd7;
    tick();
    check("t4.clamp", int'(count), 4);
    flags("t4.ld", 0, 0, 1);
    load = 1'b0; en = 1'b0;
    tick();
    check("t4.lerroff", int'(load_err), 0);
    check("t4.hold", int'(count), 4);
    load = 1'b1; en = 1'b1;
    mod_val = 4'd0; load_val = 4'd15;
    tick();
    check("t4.ld15", int'(count), 15);
    check("t4.tc15", int'(tc), 1);
    flags("t4.ld2", 0, 0, 0);
    load = 1'b0;
    tick();
    check("t4.wrap0", int'(count), 0);
    flags("t4.wr", 1, 0, 0);

    // Modulus 1: every enabled cycle wraps
    load = 1'b1; mod_val = 4'd1; load_val = 4'd0;
    tick();
    load = 1'b0;
    check("t4.m1tc", int'(tc), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4.m1cnt", int'(count), 0);
      check("t4.m1wrap", int'(wrap_pulse), 1);
    end

    // Modulus change adopted at the wrap
    mod_val = 4'd10;
    do_reset();
    en = 1'b1;
    repeat (6) tick();
    check("t5.cnt6", int'(count), 6);
    mod_val = 4'd4;
    begin
      int exp_seq[8] = '{7, 8, 9, 0, 1, 2, 3, 0};
      for (int i = 0; i < 8; i++) begin
        tick();
        check($sformatf("t5.seq%0d", i),
              int'(count), exp_seq[i]);
        check($sformatf("t5.wrap%0d", i),
              int'(wrap_pulse),
              (i == 3 || i == 7) ? 1 : 0);
      end
    end

    // Reset wins over load and en
    mod_val = 4'd10;
    do_reset();
    en = 1'b1;
    repeat (9) tick();
    check("t6.cnt9", int'(count), 9);
    reset = 1'b1; load = 1'b1; en = 1'b1;
    mod_val = 4'd3; load_val = 4'd2;
    tick();
    reset = 1'b0; load = 1'b0; en = 1'b0;
    mod_val = 4'd10;
    check("t6.cnt", int'(count), 0);
    check("t6.mod", int'(dut.mod_reg), 10);
    flags("t6.rst", 0, 0, 0);
    tick();
    check("t6.tc", int'(tc), 0);
    en = 1'b1;
    repeat (9) tick();
    check("t6.cnt9b", int'(count), 9);
    check("t6.tc9", int'(tc), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
